// File: rtl/reg_pipe.sv
// ---------------------------------------------------------------------------
// reg_pipe -- elastic pipeline register
//
// A chain of STAGES registers, each WIDTH bits wide, with one valid bit per
// stage. A stage advances whenever the stage downstream of it can make room,
// so backpressure stalls only the stages it must and empty stages (bubbles)
// are filled from upstream even while the output is stalled. A synchronous
// flush drops everything in flight without touching the data registers.
//
// Handshake (both ends): a beat transfers on a rising clock_i edge only when
// valid and ready are both high in that cycle. The producer holds in_i and
// in_valid_i stable while in_valid_i is high and in_ready_o is low. The
// consumer ignores out_o while out_valid_o is low.
//
// Parameters
//   WIDTH   data width in bits (>= 1)
//   STAGES  number of register stages (>= 1)
//   CW      occupancy count width, derived from STAGES
//
// Ports
//   clock_i      rising-edge clock
//   reset_n_i    synchronous active-low reset
//   in_i         input data
//   in_valid_i   input beat present
//   in_ready_o   pipeline accepts the input beat this cycle
//   out_o        data held in the last stage
//   out_valid_o  last stage holds a valid beat
//   out_ready_i  consumer accepts the output beat this cycle
//   flush_i      synchronous discard of all in-flight beats
//   count_o      number of stages currently holding a valid beat
// ---------------------------------------------------------------------------
module reg_pipe #(
    parameter int  WIDTH  = 8,
    parameter int  STAGES = 2,
    localparam int CW     = $clog2(STAGES + 1)
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    input  logic             flush_i,
    output logic [CW-1:0]    count_o
);

    // Stage 0 is the input side, stage STAGES-1 drives the outputs.
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;

    // Per-stage "can take a new beat this cycle".
    logic [STAGES-1:0] ready;

    // What each stage would load if it advances: the stage upstream of it,
    // or the input port for stage 0. An offered beat is masked by flush so
    // it is never accepted in a flush cycle.
    logic [WIDTH-1:0]  src_data  [STAGES];
    logic [STAGES-1:0] src_valid;

    // -----------------------------------------------------------------------
    // Ready chain. A stage is ready when it is empty or the stage after it
    // is ready; the last stage is ready when empty or when the consumer
    // takes its beat. Unrolled from the output side as a running OR so that
    // no signal feeds back into itself: ready[k] is true if any stage from k
    // to the end is empty, or out_ready_i is high.
    // -----------------------------------------------------------------------
    always_comb begin : ready_chain
        logic path_open;
        ready     = '0;
        path_open = out_ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            path_open = path_open | ~valid_q[k];
            ready[k]  = path_open;
        end
    end

    // -----------------------------------------------------------------------
    // Source selection for each stage.
    // -----------------------------------------------------------------------
    always_comb begin : source_select
        src_valid    = '0;
        src_data[0]  = in_i;
        src_valid[0] = in_valid_i & ~flush_i;
        for (int k = 1; k < STAGES; k++) begin
            src_data[k]  = data_q[k-1];
            src_valid[k] = valid_q[k-1];
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic.
    //  - flush clears every valid bit and leaves data untouched.
    //  - an advancing stage copies the upstream valid bit; data is loaded
    //    only when that incoming valid bit is set, so bubbles moving through
    //    the chain do not disturb the data registers.
    //  - a stage that is not ready holds both data and valid.
    // The occupancy count is the popcount of the next valid vector, so it is
    // registered on the same edge as the valid bits themselves.
    // -----------------------------------------------------------------------
    always_comb begin : next_state
        valid_d = valid_q;
        count_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            data_d[k] = data_q[k];
        end

        for (int k = 0; k < STAGES; k++) begin
            if (flush_i) begin
                valid_d[k] = 1'b0;
            end else if (ready[k]) begin
                valid_d[k] = src_valid[k];
                if (src_valid[k]) begin
                    data_d[k] = src_data[k];
                end
            end
        end

        for (int k = 0; k < STAGES; k++) begin
            count_d = count_d + CW'(valid_d[k]);
        end
    end

    // -----------------------------------------------------------------------
    // State registers. Reset wins over flush and over every transfer, and
    // also clears the data so the output reads zero after reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            valid_q <= '0;
            count_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. While reset is asserted the stage registers may still hold
    // stale beats, but the port advertises ready (beats offered then are
    // simply dropped by the reset). Flush always forces not-ready.
    // -----------------------------------------------------------------------
    assign in_ready_o  = (ready[0] | ~reset_n_i) & ~flush_i;
    assign out_o       = data_q[STAGES-1];
    assign out_valid_o = valid_q[STAGES-1];
    assign count_o     = count_q;

endmodule

// File: tb/tb_reg_pipe.sv
// ---------------------------------------------------------------------------
// tb_reg_pipe -- directed and random checks of reg_pipe (WIDTH=8, STAGES=3)
//
// The reference model keeps the in-flight beats as an ordered list of
// (data, position) pairs, oldest first. Each cycle the oldest beat moves up
// one position (or leaves when it is at the last position and the consumer
// is ready); every younger beat moves if the position ahead of it is free
// or the beat ahead of it moves. Directed literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_reg_pipe;

  localparam int W  = 8;
  localparam int S  = 3;
  localparam int CW = $clog2(S + 1);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          din_ready;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          flush;
  logic [CW-1:0] count;

  reg_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clock_i    (clk),
    .reset_n_i  (rst_n),
    .in_i       (din),
    .in_valid_i (din_valid),
    .in_ready_o (din_ready),
    .out_o      (dout),
    .out_valid_o(dout_valid),
    .out_ready_i(dout_ready),
    .flush_i    (flush),
    .count_o    (count)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  int           mpos[$];     // position of each in-flight beat, oldest first
  logic [W-1:0] mdat[$];     // data of each in-flight beat
  logic [W-1:0] m_last = '0; // last beat that reached the output position
  bit           mv[0:7];     // per-beat "moves this cycle"
  logic [W-1:0] exp_q[$];    // scoreboard: accepted beats awaiting delivery

  function automatic void m_moves();
    for (int i = 0; i < mpos.size(); i++) begin
      if (i == 0) mv[i] = (mpos[0] < S - 1) || dout_ready;
      else        mv[i] = (mpos[i] + 1 < mpos[i-1]) || mv[i-1];
    end
  endfunction

  function automatic bit m_ready();
    int n;
    if (!rst_n) return !flush;
    m_moves();
    n = mpos.size();
    if (n == 0) return !flush;
    return !flush && (mpos[n-1] > 0 || mv[n-1]);
  endfunction

  always @(posedge clk) begin
    bit acc;
    if (!rst_n) begin
      mpos.delete(); mdat.delete(); exp_q.delete();
      m_last = '0;
    end else begin
      acc = m_ready() && din_valid;
      if (flush) begin
        mpos.delete(); mdat.delete(); exp_q.delete();
      end else begin
        for (int i = 0; i < mpos.size(); i++) begin
          if (mv[i]) begin
            mpos[i] = mpos[i] + 1;
            if (mpos[i] == S - 1) m_last = mdat[i];
          end
        end
        if (mpos.size() > 0 && mpos[0] == S) begin
          void'(mpos.pop_front());
          void'(mdat.pop_front());
        end
        if (acc) begin
          mpos.push_back(0);
          mdat.push_back(din);
          exp_q.push_back(din);
        end
      end
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    bit           ev;
    logic [W-1:0] eo;
    if (cmp_en) begin
      ev = (mpos.size() > 0) && (mpos[0] == S - 1);
      eo = ev ? mdat[0] : m_last;
      chk("model_out_valid", int'(dout_valid), int'(ev));
      chk("model_out", int'(dout), int'(eo));
      chk("model_count", int'(count), mpos.size());
      chk("model_in_ready", int'(din_ready), int'(m_ready()));
      if (rst_n && dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_extra: got beat 0x%0h expected none", dout);
        end else begin
          chk("sb_order", int'(dout), int'(exp_q.pop_front()));
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    din = d; din_valid = 1'b1;
    step();
  endtask

  bit hold;

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0; flush = 1'b0;
    step();
    cmp_en = 1'b1;
    chk("rst_in_ready", int'(din_ready), 1);
    step();
    rst_n = 1'b1;
    chk("rst_out", int'(dout), 0);
    chk("rst_out_valid", int'(dout_valid), 0);
    chk("rst_count", int'(count), 0);

    // streaming
    dout_ready = 1'b1;
    push(8'h11); chk("st_cnt1", int'(count), 1); chk("st_ov1", int'(dout_valid), 0);
    push(8'h22); chk("st_cnt2", int'(count), 2); chk("st_ov2", int'(dout_valid), 0);
    push(8'h33); chk("st_out11", int'(dout), 'h11); chk("st_ov3", int'(dout_valid), 1);
                 chk("st_cnt3", int'(count), 3);
    push(8'h44); chk("st_out22", int'(dout), 'h22); chk("st_cnt3b", int'(count), 3);
    din_valid = 1'b0;
    step(); chk("st_out33", int'(dout), 'h33); chk("st_cnt_d2", int'(count), 2);
    step(); chk("st_out44", int'(dout), 'h44); chk("st_cnt_d1", int'(count), 1);
    step(); chk("st_empty", int'(dout_valid), 0); chk("st_cnt0", int'(count), 0);

    // fill and stall
    dout_ready = 1'b0;
    push(8'hA1); push(8'hA2); push(8'hA3);
    chk("fs_cnt3", int'(count), 3);
    din = 8'hA4; din_valid = 1'b1; #1;
    chk("fs_full_ready", int'(din_ready), 0);
    step(); chk("fs_hold_cnt", int'(count), 3); chk("fs_hold_out", int'(dout), 'hA1);
    dout_ready = 1'b1; #1;
    chk("fs_pushpop_ready", int'(din_ready), 1);
    step(); chk("fs_pp_cnt", int'(count), 3); chk("fs_pp_out", int'(dout), 'hA2);
    din_valid = 1'b0;
    step(); chk("fs_outA3", int'(dout), 'hA3);
    step(); chk("fs_outA4", int'(dout), 'hA4); chk("fs_cnt1", int'(count), 1);
    step(); chk("fs_cnt0", int'(count), 0);

    // bubble collapse
    dout_ready = 1'b0;
    push(8'h01); din_valid = 1'b0;
    step(); step();
    push(8'h02); din_valid = 1'b0;
    step(); chk("bc_cnt2", int'(count), 2); chk("bc_out01", int'(dout), 'h01);
    dout_ready = 1'b1;
    step(); chk("bc_out02", int'(dout), 'h02); chk("bc_ov", int'(dout_valid), 1);
    step(); chk("bc_cnt0", int'(count), 0);

    // flush
    dout_ready = 1'b0;
    push(8'hB1); push(8'hB2); push(8'hB3);
    chk("fl_cnt3", int'(count), 3);
    din = 8'h55; din_valid = 1'b1; flush = 1'b1; #1;
    chk("fl_in_ready", int'(din_ready), 0);
    step();
    flush = 1'b0; din_valid = 1'b0;
    chk("fl_cnt0", int'(count), 0);
    chk("fl_ov0", int'(dout_valid), 0);
    chk("fl_data_kept", int'(dout), 'hB1);
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); chk("fl_no55", int'(dout_valid), 0);
    end

    // reset mid-operation
    dout_ready = 1'b0;
    push(8'hC1); push(8'hC2); din_valid = 1'b0;
    chk("rm_cnt2", int'(count), 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rm_out0", int'(dout), 0); chk("rm_ov0", int'(dout_valid), 0);
    chk("rm_cnt0", int'(count), 0);
    dout_ready = 1'b1;
    push(8'h77); din_valid = 1'b0;
    chk("rm_lat1", int'(dout_valid), 0);
    step(); chk("rm_lat2", int'(dout_valid), 0);
    step(); chk("rm_lat3", int'(dout_valid), 1); chk("rm_out77", int'(dout), 'h77);

    // random valid/ready with occasional flush and reset
    hold = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!hold) begin
        din_valid = ($urandom_range(0, 3) != 0);
        din       = W'($urandom_range(0, 255));
      end
      dout_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 63) == 0);
      rst_n      = ($urandom_range(0, 999) != 0);
      @(negedge clk);
      hold = din_valid && !din_ready;
      step();
    end
    rst_n = 1'b1; flush = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    for (int i = 0; i < S + 1; i++) step();
    chk("end_drained", int'(count), 0);
    chk("end_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
